nec_ir_transmitter: RTL

- Encodes a 32-bit NEC IR word into a modulated 38 kHz IR drive signal. It is the transmit end of the NEC link, counterpart to the game's IR receiver.
- Used for hardware loopback of the receiver and as a remote-control emulator driven by the s1..s4 direction buttons (UP/DOWN/LEFT/RIGHT codes).
- Supports NEC repeat codes while a button is held.

---
 rtl/nec_pkg.sv | 32 +++
 rtl/nec_carrier.sv | 40 ++++
 rtl/nec_ir_transmitter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/nec_pkg.sv
// Shared NEC transmit definitions: FSM states, unit counts per symbol, remote codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nec_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP,
        REP_MARK,
        REP_SPACE,
        REP_STOP
    } nec_state_t;

    // Symbol lengths in NEC units (562.5 us each)
    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int REP_SPACE_U  = 4;
    localparam int BIT_U        = 1;
    localparam int ONE_SPACE_U  = 3;

    // Direction-button codes, packed the same way the receiver packs them
    localparam logic [31:0] UP    = 32'h20DF6A95;
    localparam logic [31:0] DOWN  = 32'h20DFEA15;
    localparam logic [31:0] LEFT  = 32'h20DF1AE5;
    localparam logic [31:0] RIGHT = 32'h20DF9A65;

endpackage

// File: rtl/nec_carrier.sv
// ~38 kHz square-wave carrier generator, gated to marks.
// Latency: carrier is high in the cycle after restart; toggles every CARRIER_HALF cycles.
// Backpressure: none; free-running while en is high, forced low otherwise.
module nec_carrier #(
    parameter int CARRIER_HALF = 658
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic en,
    input  logic restart,
    output logic carrier
);

    localparam int               CW        = $clog2(CARRIER_HALF + 1);
    localparam logic [CW-1:0]    HALF_LAST = CW'(CARRIER_HALF - 1);

    logic [CW-1:0] half_cnt;

    // Restart forces a fresh high half-period; outside marks the carrier is parked low
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            carrier  <= 1'b0;
            half_cnt <= '0;
        end else if (restart) begin
            carrier  <= 1'b1;
            half_cnt <= HALF_LAST;
        end else if (en) begin
            if (half_cnt == '0) begin
                carrier  <= ~carrier;
                half_cnt <= HALF_LAST;
            end else begin
                half_cnt <= half_cnt - CW'(1);
            end
        end else begin
            carrier  <= 1'b0;
            half_cnt <= '0;
        end
    end

endmodule

// File: rtl/nec_ir_transmitter.sv
// NEC IR transmitter: 32-bit word, MSB first, with hold-to-repeat codes and 38 kHz modulation.
// Latency: LEAD_MARK starts the cycle after start is accepted; frames repeat every FRAME_UNITS units.
// Backpressure: start is only accepted in IDLE (busy low); starts while busy are dropped.
module nec_ir_transmitter
    import nec_pkg::*;
#(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int FRAME_UNITS  = 192
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic [31:0] word,
    input  logic        start,
    input  logic        rpt,
    output logic        busy,
    output logic        done,
    output logic        ir_env,
    output logic        ir_out
);

    localparam logic [14:0] UNIT_LAST  = 15'(UNIT_CYCLES - 1);
    localparam logic [7:0]  FRAME_LAST = 8'(FRAME_UNITS - 1);

    nec_state_t  state;
    logic [14:0] unit_tmr;   // cycles left in the current unit
    logic [4:0]  st_units;   // units left in the current state, minus one
    logic [7:0]  frame_cnt;  // completed units since lead/repeat mark entry
    logic [5:0]  bit_cnt;
    logic [31:0] shreg;
    logic        carrier;

    logic unit_end;
    logic st_done;
    logic gap_done;
    logic mark_nxt;
    logic mark_entry;

    // Event decode and next-cycle mark flag (drives ir_env and the carrier restart)
    always_comb begin
        unit_end = (unit_tmr == '0);
        st_done  = unit_end && (st_units == '0);
        gap_done = (state == GAP) && unit_end && (frame_cnt == FRAME_LAST);
        mark_nxt = 1'b0;
        case (state)
            IDLE:       mark_nxt = start;
            LEAD_MARK:  mark_nxt = !st_done;
            LEAD_SPACE: mark_nxt = st_done;
            BIT_MARK:   mark_nxt = !st_done;
            BIT_SPACE:  mark_nxt = st_done;
            STOP_MARK:  mark_nxt = !st_done;
            GAP:        mark_nxt = gap_done && rpt;
            REP_MARK:   mark_nxt = !st_done;
            REP_SPACE:  mark_nxt = st_done;
            REP_STOP:   mark_nxt = !st_done;
            default:    mark_nxt = 1'b0;
        endcase
        // A mark is always preceded by a space, so entry is a rising edge of the envelope
        mark_entry = mark_nxt && !ir_env;
    end

    // Frame sequencer: symbol timing, bit shifting, frame period and registered outputs
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state     <= IDLE;
            unit_tmr  <= '0;
            st_units  <= '0;
            frame_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ir_env    <= 1'b0;
        end else begin
            done   <= 1'b0;
            ir_env <= mark_nxt;

            if (state != IDLE) begin
                unit_tmr <= unit_end ? UNIT_LAST : unit_tmr - 15'd1;
                if (unit_end) begin
                    frame_cnt <= frame_cnt + 8'd1;
                    if (st_units != '0) begin
                        st_units <= st_units - 5'd1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        shreg     <= word;
                        bit_cnt   <= '0;
                        frame_cnt <= '0;
                        unit_tmr  <= UNIT_LAST;
                        st_units  <= 5'(LEAD_MARK_U - 1);
                        busy      <= 1'b1;
                        state     <= LEAD_MARK;
                    end
                end
                LEAD_MARK: begin
                    if (st_done) begin
                        st_units <= 5'(LEAD_SPACE_U - 1);
                        state    <= LEAD_SPACE;
                    end
                end
                LEAD_SPACE: begin
                    if (st_done) begin
                        st_units <= 5'(BIT_U - 1);
                        state    <= BIT_MARK;
                    end
                end
                BIT_MARK: begin
                    if (st_done) begin
                        st_units <= shreg[31] ? 5'(ONE_SPACE_U - 1) : 5'(BIT_U - 1);
                        state    <= BIT_SPACE;
                    end
                end
                BIT_SPACE: begin
                    if (st_done) begin
                        st_units <= 5'(BIT_U - 1);
                        if (bit_cnt == 6'd31) begin
                            state <= STOP_MARK;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            shreg   <= {shreg[30:0], 1'b0};
                            state   <= BIT_MARK;
                        end
                    end
                end
                STOP_MARK: begin
                    if (st_done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        if (rpt) begin
                            frame_cnt <= '0;
                            st_units  <= 5'(LEAD_MARK_U - 1);
                            state     <= REP_MARK;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                REP_MARK: begin
                    if (st_done) begin
                        st_units <= 5'(REP_SPACE_U - 1);
                        state    <= REP_SPACE;
                    end
                end
                REP_SPACE: begin
                    if (st_done) begin
                        st_units <= 5'(BIT_U - 1);
                        state    <= REP_STOP;
                    end
                end
                REP_STOP: begin
                    if (st_done) begin
                        state <= GAP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    nec_carrier #(
        .CARRIER_HALF(CARRIER_HALF)
    ) u_carrier (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .en      (mark_nxt),
        .restart (mark_entry),
        .carrier (carrier)
    );

    // Carrier is already forced low outside marks; the AND keeps the LED off regardless
    assign ir_out = ir_env & carrier;

endmodule
